pa_round_scheduler: RTL
=======================

PA_ROUND_SCHEDULER -- requirements
Module: pa_round_scheduler

Interface
REQ-001 Parameters SHALL be: TIMEOUT_CYCLES, 24'd16_000_000, RUN-state watchdog limit; RECOVER_CYCLES, 8'd16, pa_reset_parameter hold length; MAX_KEY_LEN, 32'd1_048_576, largest legal secret key length in bits.
REQ-002 clk  in  1  single system clock (100 MHz domain); all logic SHALL be on its rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 enable  in  1  level; while high, rounds are launched back-to-back.
REQ-005 link_status  in  1  network link up; a round SHALL be launched only while it is high.
REQ-006 key_valid  in  2  level per reconciled-key buffer half (bit0 = addr0..16383, bit1 = addr16384..32767).
REQ-007 secretkey_length_cfg  in  32  requested key length in bits.
REQ-008 pa_finish / pa_fail  in  1 each  one-cycle completion pulses from the PA engine.
REQ-009 pa_start  out  1  one-cycle launch pulse to the PA engine.
REQ-010 pa_key_addr_index  out  1  buffer half used by the current round; stable from LAUNCH until the round ends.
REQ-011 pa_secretkey_length  out  32  length latched at LAUNCH.
REQ-012 pa_reset_parameter  out  1  PA parameter reset, high throughout RECOVER.
REQ-013 key_consume  out  2  one-cycle pulse freeing the buffer half just processed.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 round_cnt, fail_cnt  out  16 each  completed and failed rounds; both saturate at 16'hFFFF.
REQ-016 timeout_flag, cfg_err  out  1 each  sticky error flags.
REQ-017 state_dbg  out  3  encoded current state, for LED/ILA probing.

Function
REQ-018 The FSM SHALL have the states IDLE=0, LAUNCH=1, RUN=2, RECOVER=3, DONE=4.
REQ-019 IDLE->LAUNCH SHALL occur when enable & link_status & key_valid[next_idx] & length_ok all hold.
REQ-020 length_ok SHALL be defined as cfg != 0, cfg[5:0] == 0 (whole 64-bit words), and cfg <= MAX_KEY_LEN.
REQ-021 If launch conditions hold except length_ok, cfg_err SHALL set and the FSM SHALL stay in IDLE.
REQ-022 LAUNCH SHALL last exactly 1 cycle: pa_start = 1, latch pa_key_addr_index = next_idx, latch pa_secretkey_length, clear the watchdog, then go to RUN.
REQ-023 RUN priority, highest first:
- pa_fail -> RECOVER, fail path
- pa_finish -> DONE
- link_status low -> RECOVER, abort path
- watchdog == TIMEOUT_CYCLES-1 -> RECOVER, timeout path
REQ-024 Simultaneous pa_finish and pa_fail SHALL be treated as a fail; a pa_finish in the same cycle as watchdog expiry SHALL be treated as a success.
REQ-025 DONE SHALL last 1 cycle: key_consume[idx] = 1, round_cnt+1, next_idx toggles, then go to IDLE.
REQ-026 Fail and timeout paths SHALL pulse key_consume[idx], increment fail_cnt, and toggle next_idx on RECOVER entry; the timeout path additionally sets timeout_flag.
REQ-027 The abort path SHALL NOT consume the key and SHALL NOT toggle next_idx; fail_cnt SHALL increment.
REQ-028 RECOVER SHALL hold pa_reset_parameter high for exactly RECOVER_CYCLES cycles, then go to IDLE.
REQ-029 enable deasserting during LAUNCH/RUN/RECOVER SHALL NOT abort the round; the FSM SHALL return to IDLE and stay there.
REQ-030 pa_finish/pa_fail arriving outside RUN SHALL be ignored.
REQ-031 Minimum launch-to-launch spacing after a success SHALL be 3 cycles + PA latency.

Reset
REQ-032 When rst_n = 0 at a clock edge, the next state SHALL be IDLE, next_idx = 0, and all outputs 0, including counters, sticky flags and pa_secretkey_length.
REQ-033 A reset asserted mid-round SHALL take effect the next edge without emitting key_consume.

Structure
REQ-034 A shared package SHALL hold the state encoding and the buffer-half base constants (0, 16384).
REQ-035 The watchdog SHALL be one sub-module, pa_watchdog (24-bit counter with clear and expire output); all other logic is flat.

Verification
REQ-036 Success round: cfg = 4096, key_valid = 01, pa_finish 50 cycles after pa_start -> index 0, length 4096, key_consume = 01, round_cnt = 1, next launch waits for key_valid[1].
REQ-037 Fail: pa_fail and pa_finish in the same cycle -> fail_cnt = 1, pa_reset_parameter high 16 cycles, key_consume pulsed, round_cnt = 0.
REQ-038 Timeout: TIMEOUT_CYCLES = 100, no response -> RECOVER entered exactly 100 cycles after RUN entry, timeout_flag = 1.
REQ-039 Link drop in RUN -> RECOVER, key_consume stays 00, the next round reuses the same index.
REQ-040 cfg = 4100 or 0 -> cfg_err = 1, pa_start never asserted, busy = 0.
REQ-041 rst_n low mid-RUN -> all outputs 0 on the next cycle; saturation: force round_cnt = FFFF, one more success -> stays FFFF.

Source files
------------

// File: rtl/pa_round_scheduler_pkg.sv
// Shared definitions for the privacy-amplification round scheduler:
// FSM encoding, reconciled-key buffer half bases and small helpers.
package pa_round_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_RUN     = 3'd2,
    ST_RECOVER = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam logic [14:0] HALF0_BASE = 15'd0;
  localparam logic [14:0] HALF1_BASE = 15'd16384;

  function automatic logic [14:0] half_base(input logic idx);
    return idx ? HALF1_BASE : HALF0_BASE;
  endfunction

  // Legal key lengths are non-zero whole 64-bit words no larger than max_len.
  function automatic logic length_ok(input logic [31:0] cfg, input logic [31:0] max_len);
    return (cfg != 32'd0) && (cfg[5:0] == 6'd0) && (cfg <= max_len);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pa_round_scheduler_if.sv
// Handshake between the round scheduler (master) and the PA engine (slave).
interface pa_round_scheduler_if;
  logic        pa_start;
  logic        pa_key_addr_index;
  logic [31:0] pa_secretkey_length;
  logic        pa_reset_parameter;
  logic        pa_finish;
  logic        pa_fail;

  modport master (
    output pa_start, pa_key_addr_index, pa_secretkey_length, pa_reset_parameter,
    input  pa_finish, pa_fail
  );

  modport slave (
    input  pa_start, pa_key_addr_index, pa_secretkey_length, pa_reset_parameter,
    output pa_finish, pa_fail
  );
endinterface

// File: rtl/pa_round_scheduler_watchdog.sv
// RUN-state watchdog: counts while run is high, expire flags the last
// allowed cycle so the FSM leaves RUN exactly LIMIT cycles after entry.
module pa_watchdog #(
  parameter logic [23:0] LIMIT = 24'd16_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expire
);
  logic [23:0] cnt_q, cnt_d;

  assign expire = run && (cnt_q == LIMIT - 24'd1);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)            cnt_d = 24'd0;
    else if (run && !expire) cnt_d = cnt_q + 24'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= 24'd0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/pa_round_scheduler.sv
// Launches PA rounds on alternating reconciled-key buffer halves, watches
// for completion/failure/link loss/timeout and recovers the PA engine.
module pa_round_scheduler
  import pa_round_scheduler_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd16_000_000,
  parameter logic [7:0]  RECOVER_CYCLES = 8'd16,
  parameter logic [31:0] MAX_KEY_LEN    = 32'd1_048_576
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        link_status,
  input  logic [1:0]                  key_valid,
  input  logic [31:0]                 secretkey_length_cfg,
  pa_round_scheduler_if.master        pa,
  output logic [1:0]                  key_consume,
  output logic                        busy,
  output logic [15:0]                 round_cnt,
  output logic [15:0]                 fail_cnt,
  output logic                        timeout_flag,
  output logic                        cfg_err,
  output logic [2:0]                  state_dbg
);
  state_e      state_q, state_d;
  logic        next_idx_q, next_idx_d;
  logic        idx_q, idx_d;
  logic [31:0] len_q, len_d;
  logic [1:0]  consume_q, consume_d;
  logic [15:0] round_cnt_q, round_cnt_d;
  logic [15:0] fail_cnt_q, fail_cnt_d;
  logic        timeout_q, timeout_d;
  logic        cfg_err_q, cfg_err_d;
  logic [7:0]  rec_cnt_q, rec_cnt_d;
  logic        wd_expire;
  logic        launch_req;

  pa_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q == ST_LAUNCH),
    .run    (state_q == ST_RUN),
    .expire (wd_expire)
  );

  assign launch_req = enable && link_status && key_valid[next_idx_q];

  always_comb begin
    state_d     = state_q;
    next_idx_d  = next_idx_q;
    idx_d       = idx_q;
    len_d       = len_q;
    consume_d   = 2'b00;
    round_cnt_d = round_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    timeout_d   = timeout_q;
    cfg_err_d   = cfg_err_q;
    rec_cnt_d   = rec_cnt_q;
    case (state_q)
      ST_IDLE: if (launch_req) begin
        if (length_ok(secretkey_length_cfg, MAX_KEY_LEN)) begin
          state_d = ST_LAUNCH;
          idx_d   = next_idx_q;
          len_d   = secretkey_length_cfg;
        end else begin
          cfg_err_d = 1'b1;
        end
      end
      ST_LAUNCH: state_d = ST_RUN;
      ST_RUN: begin
        rec_cnt_d = 8'd0;
        // Fail beats finish; finish beats link loss and watchdog expiry.
        if (pa.pa_fail || (!pa.pa_finish && link_status && wd_expire)) begin
          state_d          = ST_RECOVER;
          consume_d[idx_q] = 1'b1;
          next_idx_d       = ~next_idx_q;
          fail_cnt_d       = sat_inc(fail_cnt_q);
          if (!pa.pa_fail) timeout_d = 1'b1;
        end else if (pa.pa_finish) begin
          state_d          = ST_DONE;
          consume_d[idx_q] = 1'b1;
          next_idx_d       = ~next_idx_q;
          round_cnt_d      = sat_inc(round_cnt_q);
        end else if (!link_status) begin
          state_d    = ST_RECOVER;
          fail_cnt_d = sat_inc(fail_cnt_q);
        end
      end
      ST_RECOVER: begin
        rec_cnt_d = rec_cnt_q + 8'd1;
        if (rec_cnt_q == RECOVER_CYCLES - 8'd1) state_d = ST_IDLE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      next_idx_q  <= 1'b0;
      idx_q       <= 1'b0;
      len_q       <= 32'd0;
      consume_q   <= 2'b00;
      round_cnt_q <= 16'd0;
      fail_cnt_q  <= 16'd0;
      timeout_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      rec_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      next_idx_q  <= next_idx_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      consume_q   <= consume_d;
      round_cnt_q <= round_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      timeout_q   <= timeout_d;
      cfg_err_q   <= cfg_err_d;
      rec_cnt_q   <= rec_cnt_d;
    end
  end

  assign pa.pa_start            = (state_q == ST_LAUNCH);
  assign pa.pa_key_addr_index   = idx_q;
  assign pa.pa_secretkey_length = len_q;
  assign pa.pa_reset_parameter  = (state_q == ST_RECOVER);
  assign key_consume            = consume_q;
  assign busy                   = (state_q != ST_IDLE);
  assign round_cnt              = round_cnt_q;
  assign fail_cnt               = fail_cnt_q;
  assign timeout_flag           = timeout_q;
  assign cfg_err                = cfg_err_q;
  assign state_dbg              = state_q;
endmodule
